board_edit_ctrl: RTL and testbench

- Parametrised successor to the top-level game page/cell-edit logic.
- Owns four things: the page state machine (title, help, count select, game), the active-cell count, the cursor, and a packed board of CELLS nibble-style cells.
- Consumes single-cycle key pulses from the PS2 decoder.
- Drives the packed board to the display path and a commit pulse to the buzzer path.

---
 rtl/board_edit_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_board_edit_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_edit_ctrl.sv
// Page FSM, active-cell count, cursor and packed cell board for the board edit game.
// Optional `BOARD_UNDO_EN adds an undo key pulse and a one-deep undo of the last commit.
module board_edit_ctrl #(
  parameter int unsigned CELLS    = 10,
  parameter int unsigned CELL_W   = 4,
  parameter int unsigned INIT_VAL = 1,
  parameter int unsigned IDX_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up,
  input  logic                    down,
  input  logic                    left,
  input  logic                    right,
  input  logic                    enter,
  input  logic                    space,
  input  logic                    esc,
`ifdef BOARD_UNDO_EN
  input  logic                    undo,
`endif
  output logic [1:0]              page,
  output logic [IDX_W-1:0]        count,
  output logic [IDX_W-1:0]        cursor,
  output logic [CELL_W-1:0]       staged,
  output logic [CELLS*CELL_W-1:0] board,
  output logic                    commit_p
);

  typedef enum logic [1:0] {
    PgTitle = 2'd0,
    PgHelp  = 2'd1,
    PgCount = 2'd2,
    PgGame  = 2'd3
  } page_e;

  typedef enum logic [3:0] {
    KeyNone,
    KeyEsc,
    KeyEnter,
    KeySpace,
    KeyUndo,
    KeyUp,
    KeyDown,
    KeyLeft,
    KeyRight
  } key_e;

  localparam logic [CELL_W-1:0] InitVal  = CELL_W'(INIT_VAL);
  localparam logic [IDX_W-1:0]  MaxCount = IDX_W'(CELLS);
  localparam logic [IDX_W-1:0]  IdxOne   = IDX_W'(1);
  localparam logic [CELL_W-1:0] ValOne   = CELL_W'(1);

  page_e             page_q;
  logic [IDX_W-1:0]  count_q;
  logic [IDX_W-1:0]  cursor_q;
  logic [CELL_W-1:0] staged_q;
  logic              commit_p_q;
  logic [CELL_W-1:0] cells_q [CELLS];

`ifdef BOARD_UNDO_EN
  logic              undo_valid_q;
  logic [IDX_W-1:0]  undo_idx_q;
  logic [CELL_W-1:0] undo_val_q;
`endif

  key_e              key;
  logic [IDX_W-1:0]  cur_move;
  logic [CELL_W-1:0] cell_cur;
  logic [CELL_W-1:0] cell_move;

  // Only the highest-priority pulse of a cycle is acted on.
  always_comb begin
    key = KeyNone;
    if (esc)        key = KeyEsc;
    else if (enter) key = KeyEnter;
    else if (space) key = KeySpace;
`ifdef BOARD_UNDO_EN
    else if (undo)  key = KeyUndo;
`endif
    else if (up)    key = KeyUp;
    else if (down)  key = KeyDown;
    else if (left)  key = KeyLeft;
    else if (right) key = KeyRight;
  end

  // Cursor target for left/right with wrap inside the active range.
  always_comb begin
    cur_move  = '0;
    cell_cur  = '0;
    cell_move = '0;
    if (key == KeyLeft) begin
      cur_move = (cursor_q == '0) ? count_q - IdxOne : cursor_q - IdxOne;
    end else begin
      cur_move = (cursor_q == count_q - IdxOne) ? '0 : cursor_q + IdxOne;
    end
    for (int i = 0; i < int'(CELLS); i++) begin
      if (IDX_W'(i) == cursor_q) cell_cur = cells_q[i];
      if (IDX_W'(i) == cur_move) cell_move = cells_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q     <= PgTitle;
      count_q    <= IdxOne;
      cursor_q   <= '0;
      staged_q   <= '0;
      commit_p_q <= 1'b0;
      for (int i = 0; i < int'(CELLS); i++) cells_q[i] <= InitVal;
`ifdef BOARD_UNDO_EN
      undo_valid_q <= 1'b0;
      undo_idx_q   <= '0;
      undo_val_q   <= '0;
`endif
    end else begin
      commit_p_q <= 1'b0;
      unique case (page_q)
        PgTitle: begin
          if (key == KeyEnter)      page_q <= PgCount;
          else if (key == KeySpace) page_q <= PgHelp;
        end
        PgHelp: begin
          if (key == KeyEsc)        page_q <= PgTitle;
          else if (key == KeyEnter) page_q <= PgCount;
        end
        PgCount: begin
          case (key)
            KeyUp:    if (count_q != MaxCount) count_q <= count_q + IdxOne;
            KeyDown:  if (count_q != IdxOne) count_q <= count_q - IdxOne;
            KeyEnter: begin
              page_q   <= PgGame;
              cursor_q <= '0;
              staged_q <= cells_q[0];
            end
            KeyEsc:   page_q <= PgTitle;
            default: ;
          endcase
        end
        PgGame: begin
          case (key)
            KeyLeft, KeyRight: begin
              cursor_q <= cur_move;
              staged_q <= cell_move;
            end
            KeyUp:   staged_q <= staged_q + ValOne;
            KeyDown: staged_q <= staged_q - ValOne;
            KeySpace: begin
              for (int i = 0; i < int'(CELLS); i++) begin
                if (IDX_W'(i) == cursor_q) cells_q[i] <= staged_q;
              end
              commit_p_q <= 1'b1;
`ifdef BOARD_UNDO_EN
              undo_valid_q <= 1'b1;
              undo_idx_q   <= cursor_q;
              undo_val_q   <= cell_cur;
`endif
            end
`ifdef BOARD_UNDO_EN
            KeyUndo: begin
              if (undo_valid_q) begin
                for (int i = 0; i < int'(CELLS); i++) begin
                  if (IDX_W'(i) == undo_idx_q) cells_q[i] <= undo_val_q;
                end
                cursor_q     <= undo_idx_q;
                staged_q     <= undo_val_q;
                undo_valid_q <= 1'b0;
              end
            end
`endif
            KeyEsc: begin
              page_q   <= PgTitle;
              count_q  <= IdxOne;
              cursor_q <= '0;
              staged_q <= '0;
              for (int i = 0; i < int'(CELLS); i++) cells_q[i] <= InitVal;
`ifdef BOARD_UNDO_EN
              undo_valid_q <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    board = '0;
    for (int i = 0; i < int'(CELLS); i++) board[i*CELL_W +: CELL_W] = cells_q[i];
  end

  assign page     = page_q;
  assign count    = count_q;
  assign cursor   = cursor_q;
  assign staged   = staged_q;
  assign commit_p = commit_p_q;

endmodule

// File: tb/tb_board_edit_ctrl.sv
// Randomized bench for board_edit_ctrl against a behavioural page/cell model.
module tb_board_edit_ctrl;

  localparam int CELLS    = 10;
  localparam int CELL_W   = 4;
  localparam int INIT_VAL = 1;
  localparam int IDX_W    = 5;
  localparam int BW       = CELLS * CELL_W;
  localparam int VMOD     = 1 << CELL_W;

  // Key mask bits, in priority order.
  localparam logic [7:0] M_ESC   = 8'h01;
  localparam logic [7:0] M_ENTER = 8'h02;
  localparam logic [7:0] M_SPACE = 8'h04;
  localparam logic [7:0] M_UNDO  = 8'h08;
  localparam logic [7:0] M_UP    = 8'h10;
  localparam logic [7:0] M_DOWN  = 8'h20;
  localparam logic [7:0] M_LEFT  = 8'h40;
  localparam logic [7:0] M_RIGHT = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] keys_q = 8'h00;

  logic [1:0]        page;
  logic [IDX_W-1:0]  count;
  logic [IDX_W-1:0]  cursor;
  logic [CELL_W-1:0] staged;
  logic [BW-1:0]     board;
  logic              commit_p;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int m_page, m_count, m_cursor, m_staged, m_commit;
  int m_cells [CELLS];
  int m_uv, m_ui, m_uval;

  always #5 clk = ~clk;

  board_edit_ctrl #(
    .CELLS   (CELLS),
    .CELL_W  (CELL_W),
    .INIT_VAL(INIT_VAL),
    .IDX_W   (IDX_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .up      (keys_q[4]),
    .down    (keys_q[5]),
    .left    (keys_q[6]),
    .right   (keys_q[7]),
    .enter   (keys_q[1]),
    .space   (keys_q[2]),
    .esc     (keys_q[0]),
`ifdef BOARD_UNDO_EN
    .undo    (keys_q[3]),
`endif
    .page    (page),
    .count   (count),
    .cursor  (cursor),
    .staged  (staged),
    .board   (board),
    .commit_p(commit_p)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_page = 0; m_count = 1; m_cursor = 0; m_staged = 0; m_commit = 0; m_uv = 0;
    for (int i = 0; i < CELLS; i++) m_cells[i] = INIT_VAL % VMOD;
  endfunction

  function automatic logic [BW-1:0] m_board();
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < CELLS; i++) r[i*CELL_W +: CELL_W] = CELL_W'(m_cells[i]);
    return r;
  endfunction

  function automatic void model_step(input logic [7:0] m);
    int k;
    k = 8;
    for (int b = 7; b >= 0; b--) if (m[b]) k = b;
    m_commit = 0;
    case (m_page)
      0: if (k == 1) m_page = 2; else if (k == 2) m_page = 1;
      1: if (k == 0) m_page = 0; else if (k == 1) m_page = 2;
      2: begin
        if (k == 4 && m_count < CELLS) m_count++;
        else if (k == 5 && m_count > 1) m_count--;
        else if (k == 1) begin m_page = 3; m_cursor = 0; m_staged = m_cells[0]; end
        else if (k == 0) m_page = 0;
      end
      default: begin
        case (k)
          0: model_reset();
          2: begin
            m_uv = 1; m_ui = m_cursor; m_uval = m_cells[m_cursor];
            m_cells[m_cursor] = m_staged; m_commit = 1;
          end
          3: if (m_uv != 0) begin
            m_cells[m_ui] = m_uval; m_cursor = m_ui; m_staged = m_uval; m_uv = 0;
          end
          4: m_staged = (m_staged + 1) % VMOD;
          5: m_staged = (m_staged + VMOD - 1) % VMOD;
          6: begin m_cursor = (m_cursor + m_count - 1) % m_count; m_staged = m_cells[m_cursor]; end
          7: begin m_cursor = (m_cursor + 1) % m_count; m_staged = m_cells[m_cursor]; end
          default: ;
        endcase
      end
    endcase
  endfunction

  always @(posedge clk) if (rst_n) model_step(keys_q);
  always @(negedge rst_n) model_reset();

  // Compare process: DUT against model every cycle, mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("page", 256'(page), 256'(m_page));
      chk("count", 256'(count), 256'(m_count));
      chk("cursor", 256'(cursor), 256'(m_cursor));
      chk("staged", 256'(staged), 256'(m_staged));
      chk("board", 256'(board), 256'(m_board()));
      chk("commit_p", 256'(commit_p), 256'(m_commit));
    end
  end

  task automatic step(input logic [7:0] m);
    keys_q = m;
    @(posedge clk);
    #2;
    keys_q = 8'h00;
  endtask

  task automatic step_n(input logic [7:0] m, input int n);
    for (int i = 0; i < n; i++) step(m);
  endtask

  logic [7:0] rm;
  int         kr;

  initial begin
    model_reset();
    #1;
    rst_n = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("lit_rst_page", 256'(page), 256'(0));
    chk("lit_rst_count", 256'(count), 256'(1));
    chk("lit_rst_cursor", 256'(cursor), 256'(0));
    chk("lit_rst_staged", 256'(staged), 256'(0));
    chk("lit_rst_board", 256'(board), 256'(40'h1111111111));
    chk("lit_rst_commit", 256'(commit_p), 256'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    step(M_ENTER);
    chk("lit_count_page", 256'(page), 256'(2));
    step_n(M_UP, 12);
    chk("lit_count_sat_hi", 256'(count), 256'(10));
    step_n(M_DOWN, 15);
    chk("lit_count_sat_lo", 256'(count), 256'(1));
    step_n(M_UP, 2);
    chk("lit_count3", 256'(count), 256'(3));
    step(M_ENTER);
    chk("lit_game_page", 256'(page), 256'(3));
    chk("lit_game_staged", 256'(staged), 256'(1));
    step(M_LEFT);
    chk("lit_left_wrap", 256'(cursor), 256'(2));
    step_n(M_RIGHT, 2);
    chk("lit_right_wrap", 256'(cursor), 256'(1));
    step(M_RIGHT);
    chk("lit_right", 256'(cursor), 256'(2));
    step(M_RIGHT);
    chk("lit_right_wrap0", 256'(cursor), 256'(0));
    step(M_DOWN);
    chk("lit_staged_dec", 256'(staged), 256'(0));
    step(M_DOWN);
    chk("lit_staged_wrap", 256'(staged), 256'(15));
    step(M_SPACE);
    chk("lit_commit_cell0", 256'(board), 256'(40'h111111111F));
    chk("lit_commit_pulse", 256'(commit_p), 256'(1));
    step(8'h00);
    chk("lit_commit_drop", 256'(commit_p), 256'(0));
    step(M_RIGHT);
    step(M_LEFT);
    chk("lit_staged_reload", 256'(staged), 256'(15));
    step(M_SPACE);
    step(M_SPACE);
    chk("lit_b2b_commit", 256'(commit_p), 256'(1));
    step(M_UP | M_RIGHT);
    chk("lit_up_over_right_cur", 256'(cursor), 256'(0));
    chk("lit_up_over_right_stg", 256'(staged), 256'(0));
    step(M_ESC | M_SPACE);
    chk("lit_esc_page", 256'(page), 256'(0));
    chk("lit_esc_board", 256'(board), 256'(40'h1111111111));
    chk("lit_esc_commit", 256'(commit_p), 256'(0));

    // Reset in the middle of an edit.
    step(M_ENTER);
    step(M_ENTER);
    step(M_DOWN);
    rst_n = 1'b0;
    #1;
    chk("lit_midrst_staged", 256'(staged), 256'(0));
    chk("lit_midrst_page", 256'(page), 256'(0));
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

`ifdef BOARD_UNDO_EN
    step(M_ENTER);
    step(M_UP);
    step(M_ENTER);
    step_n(M_DOWN, 2);
    step(M_SPACE);
    step(M_RIGHT);
    step(M_UNDO);
    chk("lit_undo_board", 256'(board), 256'(40'h1111111111));
    chk("lit_undo_cursor", 256'(cursor), 256'(0));
    chk("lit_undo_staged", 256'(staged), 256'(1));
    step(M_RIGHT);
    step(M_UNDO);
    chk("lit_undo2_cursor", 256'(cursor), 256'(1));
    step(M_ESC);
`endif

    for (int n = 0; n < 4000; n++) begin
      kr = $urandom_range(0, 99);
      rm = 8'h00;
      if (kr < 3)       rm = M_ESC;
      else if (kr < 15) rm = M_ENTER;
      else if (kr < 25) rm = M_SPACE;
      else if (kr < 30) rm = M_UNDO;
      else if (kr < 50) rm = M_UP;
      else if (kr < 65) rm = M_DOWN;
      else if (kr < 80) rm = M_LEFT;
      else if (kr < 95) rm = M_RIGHT;
      if ($urandom_range(0, 9) == 0) rm[$urandom_range(0, 7)] = 1'b1;
`ifndef BOARD_UNDO_EN
      rm[3] = 1'b0;
`endif
      step(rm);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
